inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 2, instruction queue entries (power of two, >=2).
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 redirect  input  1  branch/jump taken; flush and refetch.
REQ-006 redirect_pc  input  32  new fetch address; bits [1:0] ignored, forced to 00.
REQ-007 imem_req  output  1  instruction memory request active.
REQ-008 imem_addr  output  32  word-aligned fetch address, stable while imem_req high.
REQ-009 imem_ack  input  1  memory transfer complete this cycle; meaningful only while imem_req high.
REQ-010 imem_data  input  32  instruction word, valid when imem_req && imem_ack.
REQ-011 out_valid  output  1  queue head holds an instruction for the decoder.
REQ-012 out_inst  output  32  head instruction word, raw 32-bit MIPS encoding.
REQ-013 out_pc  output  32  address of out_inst.
REQ-014 out_ready  input  1  decoder consumes head this cycle.

Function
REQ-015 Transfer on the memory side SHALL occur on any cycle with imem_req && imem_ack; latency 0..N cycles, at most one request outstanding.
REQ-016 FSM states: IDLE (no request), REQ (request outstanding, result kept), DROP (request outstanding, result discarded); imem_req = (state==REQ || state==DROP).
REQ-017 IDLE->REQ when no redirect and count_after_pop < DEPTH; otherwise remain IDLE.
REQ-018 REQ with ack, no redirect: push {fetch_pc, imem_data}, fetch_pc += 4; next REQ if queue still has room after push/pop, else IDLE.
REQ-019 REQ without ack, no redirect: remain REQ, imem_addr unchanged.
REQ-020 redirect SHALL flush the queue (count=0) in that cycle; a simultaneous pop is void; fetch_pc <= {redirect_pc[31:2],2'b00}.
REQ-021 redirect in IDLE, or in REQ with ack same cycle: returned word discarded, next state REQ at the new fetch_pc.
REQ-022 redirect in REQ without ack: next state DROP; imem_addr keeps the old address until ack.
REQ-023 DROP with ack: word discarded, fetch_pc unchanged, next REQ; DROP without ack: stay; redirect in DROP only updates fetch_pc.
REQ-024 imem_addr = fetch_pc in IDLE/REQ; in DROP it SHALL be the held old address.
REQ-025 Pop when out_valid && out_ready && !redirect; push and pop in one cycle leave count unchanged.
REQ-026 out_valid = (count != 0); pushed entry visible at outputs the cycle after ack (1-cycle latency).
REQ-027 Throughput: ack every cycle with out_ready high SHALL sustain one instruction per cycle.
REQ-028 Push never occurs with count == DEPTH (guaranteed by REQ-017/018); fetch_pc wraps 32'hFFFF_FFFC -> 32'h0.
REQ-029 out_inst/out_pc SHALL hold their value while out_valid && !out_ready.

Reset
REQ-030 rst_n low SHALL immediately force: state IDLE, count 0, imem_req 0, out_valid 0, fetch_pc=imem_addr=RESET_PC, queue storage and out_inst/out_pc 0.
REQ-031 Reset mid-request abandons the request; first imem_req after release at RESET_PC, one cycle after the first rising edge.

Structure
REQ-032 Shared header Core.vh SHALL hold the default RESET_PC and the FSM state encodings.
REQ-033 Queue SHALL be a sub-module inst_queue (sync FIFO: push, pop, flush, count, head data).

Verification
REQ-034 Reset release, imem_ack tied high, out_ready high -> addresses 0x0,0x4,0x8 on consecutive cycles; out_pc follows one cycle later.
REQ-035 out_ready low, ack every cycle, DEPTH=2 -> exactly two entries (pc 0x0,0x4), imem_req drops; raise out_ready -> fetch of 0x8 resumes.
REQ-036 Request to 0x10 with ack delayed 3 cycles, redirect_pc=0x40 in cycle 1 -> 0x10 held until ack, word discarded, next request 0x40, out_valid stays 0.
REQ-037 redirect_pc=0x83 with simultaneous ack and pop, count=1 -> queue empty next cycle, next imem_addr 0x80.
REQ-038 fetch_pc=0xFFFFFFFC, ack -> entry pc 0xFFFFFFFC, next imem_addr 0x0.
REQ-039 rst_n low while REQ outstanding -> imem_req and out_valid 0 immediately, no clock; after release first address RESET_PC.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: default reset PC,
// fetch FSM state encodings and the queue entry payload.
package inst_fetch_queue_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_DROP = 2'b10
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fq_entry_t;

endpackage

// File: rtl/inst_fetch_queue_queue.sv
// inst_queue: synchronous FIFO of fetched {pc, inst} entries with flush.
// Flush wins over push and pop in the same cycle.
module inst_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           push_i,
   input  fq_entry_t                      push_data_i,
   input  logic                           pop_i,
   input  logic                           flush_i,
   output logic [$clog2(DEPTH+1)-1:0]     count_o,
   output fq_entry_t                      head_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   fq_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push_c;
   logic             do_pop_c;

   assign do_push_c = push_i && !flush_i && (count_q != CNT_W'(DEPTH));
   assign do_pop_c  = pop_i && !flush_i && (count_q != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (do_push_c) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (do_push_c && !do_pop_c) begin
            count_q <= count_q + CNT_W'(1);
         end else if (!do_push_c && do_pop_c) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: single-outstanding memory request FSM feeding
// an instruction queue, with redirect flush and discard of in-flight words.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   output logic        out_valid,
   output logic [31:0] out_inst,
   output logic [31:0] out_pc,
   input  logic        out_ready
);

   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   fetch_state_e     state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      drop_addr_q, drop_addr_d;
   logic [CNT_W-1:0] count_c;
   logic [CNT_W-1:0] cnt_after_pop_c;
   logic             pop_c;
   logic             push_c;
   logic [31:0]      redirect_pc_al_c;
   logic             unused_pc_bits_c;
   fq_entry_t        head_c;
   fq_entry_t        push_entry_c;

   assign redirect_pc_al_c = {redirect_pc[31:2], 2'b00};
   assign unused_pc_bits_c = ^redirect_pc[1:0];

   assign pop_c           = (count_c != '0) && out_ready && !redirect;
   assign cnt_after_pop_c = count_c - CNT_W'(pop_c);
   assign push_entry_c    = '{pc: fetch_pc_q, inst: imem_data};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         fetch_pc_q  <= RESET_PC;
         drop_addr_q <= RESET_PC;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         drop_addr_q <= drop_addr_d;
      end
   end

   // Next state: REQ keeps its word, DROP waits out a request made stale by a redirect.
   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      drop_addr_d = drop_addr_q;
      push_c      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (redirect) begin
               fetch_pc_d = redirect_pc_al_c;
               state_d    = ST_REQ;
            end else if (cnt_after_pop_c < CNT_W'(DEPTH)) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (redirect) begin
               fetch_pc_d = redirect_pc_al_c;
               if (imem_ack) begin
                  state_d = ST_REQ;
               end else begin
                  drop_addr_d = fetch_pc_q;
                  state_d     = ST_DROP;
               end
            end else if (imem_ack) begin
               push_c     = 1'b1;
               fetch_pc_d = fetch_pc_q + 32'd4;
               state_d    = (cnt_after_pop_c < CNT_W'(DEPTH - 1)) ? ST_REQ : ST_IDLE;
            end
         end
         ST_DROP: begin
            if (redirect) fetch_pc_d = redirect_pc_al_c;
            if (imem_ack) state_d = ST_REQ;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   inst_queue #(.DEPTH(DEPTH)) u_queue (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push_c),
      .push_data_i (push_entry_c),
      .pop_i       (pop_c),
      .flush_i     (redirect),
      .count_o     (count_c),
      .head_o      (head_c)
   );

   assign imem_req  = (state_q == ST_REQ) || (state_q == ST_DROP);
   assign imem_addr = (state_q == ST_DROP) ? drop_addr_q : fetch_pc_q;
   assign out_valid = (count_c != '0);
   assign out_inst  = head_c.inst;
   assign out_pc    = head_c.pc;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: directed scenarios plus random
// traffic compared against a transaction-level model of the fetch queue.
module tb_inst_fetch_queue;

   localparam int unsigned DEPTH  = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_data = '0;
   logic        out_valid;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_ready = 1'b0;

   always #5 clk = ~clk;

   inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .out_valid   (out_valid),
      .out_inst    (out_inst),
      .out_pc      (out_pc),
      .out_ready   (out_ready)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   ent_t        mq[$];
   logic [31:0] m_pc;
   logic [31:0] m_addr;
   bit          m_busy;
   bit          m_keep;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc   = RST_PC;
      m_addr = RST_PC;
      m_busy = 1'b0;
      m_keep = 1'b0;
   endtask

   task automatic check_outputs();
      chk("imem_req", 32'(imem_req), 32'(m_busy));
      chk("imem_addr", imem_addr, m_busy ? m_addr : m_pc);
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("out_pc", out_pc, mq[0].pc);
         chk("out_inst", out_inst, mq[0].inst);
      end
   endtask

   // One clock: sample the driven inputs, advance the model, settle past the edge.
   task automatic step();
      logic        s_redir, s_ack, s_rdy;
      logic [31:0] s_rpc, s_data;
      bit          do_pop;
      s_redir = redirect;
      s_ack   = imem_ack;
      s_rdy   = out_ready;
      s_rpc   = redirect_pc;
      s_data  = imem_data;
      @(posedge clk);
      do_pop = (mq.size() != 0) && s_rdy && !s_redir;
      if (s_redir) begin
         mq.delete();
         m_pc = {s_rpc[31:2], 2'b00};
      end else begin
         if (do_pop) void'(mq.pop_front());
         if (m_busy && s_ack && m_keep) begin
            mq.push_back('{pc: m_addr, inst: s_data});
            m_pc = m_pc + 32'd4;
         end
      end
      if (m_busy && !s_ack) begin
         if (s_redir) m_keep = 1'b0;
      end else if (s_redir || mq.size() < DEPTH) begin
         m_busy = 1'b1;
         m_keep = 1'b1;
         m_addr = m_pc;
      end else begin
         m_busy = 1'b0;
      end
      #1;
   endtask

   task automatic cycle(input logic redir, input logic [31:0] rpc,
                        input logic ack, input logic rdy);
      redirect    = redir;
      redirect_pc = rpc;
      imem_ack    = ack;
      out_ready   = rdy;
      imem_data   = $urandom;
      check_outputs();
      step();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      model_reset();
      rst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      #12;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_pc", out_pc, 32'd0);
      chk("rst_inst", out_inst, 32'd0);
      rst_n = 1'b1;

      // Streaming: ack and ready always high.
      cycle(1'b0, '0, 1'b1, 1'b1);
      chk("s_addr0", imem_addr, 32'h0);
      cycle(1'b0, '0, 1'b1, 1'b1);
      chk("s_addr4", imem_addr, 32'h4);
      chk("s_pc0", out_pc, 32'h0);
      cycle(1'b0, '0, 1'b1, 1'b1);
      chk("s_addr8", imem_addr, 32'h8);
      chk("s_pc4", out_pc, 32'h4);

      // Backpressure fills the queue and stalls fetching.
      do_reset();
      repeat (4) cycle(1'b0, '0, 1'b1, 1'b0);
      chk("bp_req", 32'(imem_req), 32'd0);
      chk("bp_pc", out_pc, 32'h0);
      cycle(1'b0, '0, 1'b1, 1'b1);
      chk("bp_resume_req", 32'(imem_req), 32'd1);
      chk("bp_resume_addr", imem_addr, 32'h8);

      // Redirect while a request is outstanding: old address held, word dropped.
      do_reset();
      cycle(1'b1, 32'h10, 1'b0, 1'b1);
      chk("dr_addr10", imem_addr, 32'h10);
      cycle(1'b1, 32'h40, 1'b0, 1'b1);
      chk("dr_hold", imem_addr, 32'h10);
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("dr_hold2", imem_addr, 32'h10);
      cycle(1'b0, '0, 1'b1, 1'b1);
      chk("dr_new", imem_addr, 32'h40);
      chk("dr_valid", 32'(out_valid), 32'd0);

      // Redirect with simultaneous ack and pop, one entry queued.
      do_reset();
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      cycle(1'b1, 32'h83, 1'b1, 1'b1);
      chk("rap_valid", 32'(out_valid), 32'd0);
      chk("rap_addr", imem_addr, 32'h80);

      // PC wrap at the top of the address space.
      do_reset();
      cycle(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0);
      chk("wrap_pc", out_pc, 32'hFFFF_FFFC);
      chk("wrap_addr", imem_addr, 32'h0);

      // Asynchronous reset with a request outstanding and queue non-empty.
      cycle(1'b0, '0, 1'b0, 1'b0);
      rst_n = 1'b0;
      #2;
      chk("ar_req", 32'(imem_req), 32'd0);
      chk("ar_valid", 32'(out_valid), 32'd0);
      chk("ar_addr", imem_addr, RST_PC);
      chk("ar_pc", out_pc, 32'd0);
      model_reset();
      rst_n = 1'b1;
      cycle(1'b0, '0, 1'b0, 1'b0);
      chk("ar_first", imem_addr, RST_PC);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic        r_redir, r_ack, r_rdy;
         logic [31:0] r_pc;
         if ($urandom_range(0, 399) == 0) do_reset();
         r_redir = ($urandom_range(0, 99) < 7);
         r_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : $urandom;
         if ((i / 200) % 3 == 2) begin
            r_ack = 1'b1;
            r_rdy = 1'b1;
         end else begin
            r_ack = ($urandom_range(0, 99) < 60);
            r_rdy = ($urandom_range(0, 99) < 65);
         end
         cycle(r_redir, r_pc, r_ack, r_rdy);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
